// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple_processor pipeline.
// The fetch stage uses the state enum and the buffered entry layout.
package simple_processor_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int PC_STEP    = 2;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// First-word-fall-through FIFO used between fetch and decode.
module fetch_buffer
  import simple_processor_pkg::*;
#(
  parameter  int WIDTH = $bits(fetch_entry_t),
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  // Guarded locally so misuse by a future client cannot corrupt the pointers.
  assign push_en = push_i & (count_q != FULL_CNT);
  assign pop_en  = pop_i & (count_q != '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests one at a time
// and queues fetched instructions for decode; redirects restart the stream.
module instr_fetch_unit #(
  parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int PC_STEP        = simple_processor_pkg::PC_STEP,
  parameter int BUF_DEPTH      = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      imem_ack_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      instr_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i
);

  import simple_processor_pkg::*;

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] STEP     = MEM_ADDR_WIDTH'(PC_STEP);

  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] instr;
    logic [MEM_ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e              state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_ADDR_WIDTH-1:0] target_q, target_d;
  logic                      push;
  logic                      pop;
  logic                      flush;
  logic                      done;
  logic [CNT_W-1:0]          count;
  entry_t                    push_entry;
  entry_t                    head;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  // In DISCARD pc_q still holds the abandoned address, so the bus stays stable.
  assign imem_req_o  = ((state_q == FETCH) && (count < FULL_CNT)) || (state_q == DISCARD);
  assign imem_addr_o = pc_q;
  assign done        = imem_req_o & imem_ack_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    push     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d    = boot_addr_i;
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_i) begin
          flush = 1'b1;
          if (imem_req_o && !imem_ack_i) begin
            target_d = redirect_addr_i;
            state_d  = DISCARD;
          end else begin
            pc_d = redirect_addr_i;
          end
        end else if (done) begin
          push = 1'b1;
          pc_d = pc_q + STEP;
        end
      end
      DISCARD: begin
        flush = redirect_i;
        if (imem_ack_i) begin
          pc_d    = redirect_i ? redirect_addr_i : target_q;
          state_d = FETCH;
        end else if (redirect_i) begin
          target_d = redirect_addr_i;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign push_entry = '{instr: imem_rdata_i, pc: pc_q};
  assign pop        = instr_valid_o & instr_ready_i;

  fetch_buffer #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr_valid_o = (count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table,
// an asynchronous-reset sequence, and randomized traffic against a queue model.
module tb_instr_fetch_unit;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] boot_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (DW),
    .PC_STEP        (2),
    .BUF_DEPTH      (DEPTH)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .boot_addr_i     (boot_addr),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_rdata_i    (imem_rdata),
    .imem_ack_i      (imem_ack),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (instr_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the PC is simply "next address to fetch", the buffer a queue,
  // and a flag records that the outstanding request's data must be thrown away.
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t          mq[$];
  bit            m_booted;
  bit            m_disc;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_target;

  function automatic bit m_req();
    return m_booted && (m_disc || (mq.size() < DEPTH));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_booted = 1'b0;
    m_disc   = 1'b0;
    m_pc     = '0;
    m_target = '0;
  endtask

  task automatic model_check();
    check("req", imem_req, m_req());
    check("addr", imem_addr, m_pc);
    check("valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("instr_pc", instr_pc, mq[0].pc);
      check("instr", instr, mq[0].instr);
    end
  endtask

  task automatic model_next();
    bit req_now;
    bit done;
    if (arst) begin
      model_reset();
      return;
    end
    if (!m_booted) begin
      m_pc     = boot_addr;
      m_booted = 1'b1;
      return;
    end
    req_now = m_req();
    done    = req_now && imem_ack;
    if ((mq.size() != 0) && instr_ready) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
      if (m_disc) begin
        if (done) begin
          m_pc   = redirect_addr;
          m_disc = 1'b0;
        end else begin
          m_target = redirect_addr;
        end
      end else if (req_now && !imem_ack) begin
        m_disc   = 1'b1;
        m_target = redirect_addr;
      end else begin
        m_pc = redirect_addr;
      end
    end else if (m_disc) begin
      if (done) begin
        m_pc   = m_target;
        m_disc = 1'b0;
      end
    end else if (done) begin
      mq.push_back('{instr: imem_rdata, pc: m_pc});
      m_pc = m_pc + AW'(2);
    end
  endtask

  task automatic settle_and_check();
    #1;
    if (arst) model_reset();
    model_check();
  endtask

  task automatic advance();
    model_next();
    @(negedge clk);
  endtask

  task automatic step();
    settle_and_check();
    advance();
  endtask

  typedef struct {
    bit            rst;
    logic [AW-1:0] boot;
    bit            ack;
    bit            ready;
    bit            redir;
    logic [AW-1:0] raddr;
    bit            e_req;
    logic [AW-1:0] e_addr;
    bit            e_valid;
    logic [AW-1:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input logic [AW-1:0] boot, input bit ack, input bit ready,
                     input bit redir, input logic [AW-1:0] raddr, input bit e_req,
                     input logic [AW-1:0] e_addr, input bit e_valid, input logic [AW-1:0] e_pc);
    vec_t v;
    v = '{rst, boot, ack, ready, redir, raddr, e_req, e_addr, e_valid, e_pc};
    tbl.push_back(v);
  endtask

  logic [AW-1:0] b;

  initial begin
    arst          = 1'b1;
    boot_addr     = '0;
    imem_rdata    = '0;
    imem_ack      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b0;
    model_reset();
    @(negedge clk);

    // Sequential stream from boot address with zero-wait ack.
    b = 16'h0100;
    add(1, b, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'h0100, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'h0102, 1, 16'h0100);
    add(0, b, 1, 1, 0, 0, 1, 16'h0104, 1, 16'h0102);
    add(0, b, 1, 1, 0, 0, 1, 16'h0106, 1, 16'h0104);
    // Back-pressure: buffer fills, then one pop allows exactly one more fetch.
    add(1, b, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 0, 0, 0, 1, 16'h0100, 0, 0);
    add(0, b, 1, 0, 0, 0, 1, 16'h0102, 1, 16'h0100);
    add(0, b, 1, 0, 0, 0, 0, 16'h0104, 1, 16'h0100);
    add(0, b, 1, 1, 0, 0, 0, 16'h0104, 1, 16'h0100);
    add(0, b, 1, 0, 0, 0, 1, 16'h0104, 1, 16'h0102);
    add(0, b, 1, 0, 0, 0, 0, 16'h0106, 1, 16'h0102);
    // Redirect while a request waits: address held, data dropped.
    b = 16'h0200;
    add(1, b, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 0, 1, 0, 0, 1, 16'h0200, 0, 0);
    add(0, b, 0, 1, 1, 16'h0400, 1, 16'h0200, 0, 0);
    add(0, b, 0, 1, 0, 0, 1, 16'h0200, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'h0200, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'h0400, 0, 0);
    add(0, b, 0, 1, 0, 0, 1, 16'h0402, 1, 16'h0400);
    add(0, b, 0, 1, 0, 0, 1, 16'h0402, 0, 0);
    // Redirect in the same cycle as the ack.
    b = 16'h0010;
    add(1, b, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 1, 1, 16'h0040, 1, 16'h0010, 0, 0);
    add(0, b, 1, 0, 0, 0, 1, 16'h0040, 0, 0);
    add(0, b, 0, 0, 0, 0, 1, 16'h0042, 1, 16'h0040);
    // Second redirect arriving with the discard ack wins over the stored target.
    b = 16'h0300;
    add(1, b, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 0, 0, 1, 16'h0600, 1, 16'h0300, 0, 0);
    add(0, b, 1, 0, 1, 16'h0700, 1, 16'h0300, 0, 0);
    add(0, b, 1, 0, 0, 0, 1, 16'h0700, 0, 0);
    add(0, b, 0, 0, 0, 0, 1, 16'h0702, 1, 16'h0700);
    // PC wrap at the top of the address space.
    b = 16'hFFFE;
    add(1, b, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'hFFFE, 0, 0);
    add(0, b, 1, 1, 0, 0, 1, 16'h0000, 1, 16'hFFFE);
    add(0, b, 0, 1, 0, 0, 1, 16'h0002, 1, 16'h0000);
    add(0, b, 0, 1, 0, 0, 1, 16'h0002, 0, 0);

    foreach (tbl[i]) begin
      arst          = tbl[i].rst;
      boot_addr     = tbl[i].boot;
      imem_ack      = tbl[i].ack;
      instr_ready   = tbl[i].ready;
      redirect      = tbl[i].redir;
      redirect_addr = tbl[i].raddr;
      imem_rdata    = imem_addr ^ 16'h5A5A;
      settle_and_check();
      check($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
        check($sformatf("tbl%0d_instr", i), instr, tbl[i].e_pc ^ 16'h5A5A);
      end
      advance();
    end

    // Asynchronous reset while a request is outstanding.
    arst        = 1'b1;
    boot_addr   = 16'h0300;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    step();
    arst = 1'b0;
    step();
    step();
    #2;
    arst = 1'b1;
    #1;
    check("async_req", imem_req, 1'b0);
    check("async_addr", imem_addr, 16'h0000);
    check("async_valid", instr_valid, 1'b0);
    model_reset();
    @(negedge clk);
    boot_addr = 16'h0A00;
    step();
    arst = 1'b0;
    step();
    #1;
    check("reboot_req", imem_req, 1'b1);
    check("reboot_addr", imem_addr, 16'h0A00);
    @(negedge clk);
    model_next();

    // Randomized traffic against the model.
    for (int seg = 0; seg < 4; seg++) begin
      arst      = 1'b1;
      boot_addr = AW'($urandom) & 16'hFFFE;
      if (seg == 3) boot_addr = 16'hFFF8;
      imem_ack  = 1'b0;
      redirect  = 1'b0;
      step();
      arst = 1'b0;
      for (int c = 0; c < 600; c++) begin
        arst          = ($urandom_range(0, 299) == 0);
        imem_ack      = ($urandom_range(0, 9) < 6);
        instr_ready   = ($urandom_range(0, 9) < (seg == 1 ? 2 : 6));
        redirect      = ($urandom_range(0, 19) == 0);
        redirect_addr = AW'($urandom) & 16'hFFFE;
        imem_rdata    = DW'($urandom);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
